i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
Synthesizable, parametrised I2C slave with an internal byte register file. It is the successor to the behavioural slave BFM hung on the master's bus. It oversamples SCL/SDA with the system clock, filters glitches, and decodes START, STOP and repeated START. It supports pointer-based multi-byte writes and reads with auto-increment. A side host port lets the bench or SoC read the register file directly.

Parameters:
I2C_ADR, 7'h10, 7-bit slave address.
MEM_AW, 4, register-file address width; depth = 2**MEM_AW (1..8).
FILT_LEN, 3, consecutive identical samples needed to update a filtered line (1..15).
STRETCH_CYC, 16, SCL low-hold length in wb_clk_i cycles (used only with I2C_STRETCH_EN).

Ports:
wb_clk_i  in  1  system clock; the only clock.
arst_i  in  1  asynchronous, active-low reset.
scl_pad_i  in  1  SCL line input.
sda_pad_i  in  1  SDA line input.
scl_pad_o  out  1  SCL output, constant 0.
scl_padoen_o  out  1  SCL output enable, active low.
sda_pad_o  out  1  SDA output, constant 0.
sda_padoen_o  out  1  SDA output enable, active low.
hst_adr_i  in  MEM_AW  host read address.
hst_dat_o  out  8  mem[hst_adr_i], combinational read.
busy_o  out  1  high from START to STOP while the slave is addressed.
wr_stb_o  out  1  one-cycle pulse per byte written to the register file.
wr_adr_o  out  MEM_AW  address of the last written byte.

Behaviour:
- Reset values (arst_i=0, asynchronous): scl_padoen_o=1, sda_padoen_o=1, busy_o=0, wr_stb_o=0, wr_adr_o=0, pointer=0, state=IDLE, mem cleared to 0x00, filtered SCL=1, filtered SDA=1.
- Input path: 2-flop synchronizer, then filter. A filtered line changes only after FILT_LEN equal consecutive synchronized samples.
- Edge events come from the filtered lines:
  - scl_rise / scl_fall: SCL edges.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
- Sampling and driving:
  - Data bits are sampled on scl_rise, MSB first.
  - SDA is changed only on the cycle after scl_fall.
- STOP in any state returns to IDLE, releases SDA and clears busy_o.
- START in any state (including repeated START) enters ADDR with a cleared bit counter.
- A partially received byte is discarded on START or STOP.
- FSM:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th scl_rise, if addr[7:1]==I2C_ADR go to ADR_ACK, else go to IDLE (SDA released, NACK).
  - ADR_ACK: drive SDA low from the scl_fall after bit 8 until the next scl_fall. Set busy_o. Then go to PTR if R/W=0, or RD if R/W=1.
  - PTR: shift 8 bits; pointer <= byte[MEM_AW-1:0] (upper bits ignored). Then PTR_ACK (ACK as above), then WR.
  - WR: shift 8 bits. On the 8th scl_rise write mem[pointer], pulse wr_stb_o, set wr_adr_o=pointer, and pointer <= pointer+1 mod 2**MEM_AW. Then WR_ACK, then WR.
  - RD: load mem[pointer] at entry. Drive bit 7 after the ACK-phase scl_fall and each following bit after each scl_fall; a 1 bit releases SDA, a 0 bit drives it low. After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on scl_rise. On ACK (SDA=0): pointer+1 (wrap), then RD. On NACK: go to IDLE with SDA released.
- Pointer wrap: writes or reads past 2**MEM_AW-1 continue at 0.
- Host port: hst_dat_o reflects the register file. If the host reads the address being written in the same cycle, it returns the old value.
- Reset asserted mid-transfer: all outputs go to reset values immediately; the bus is released.

Optional Feature:
I2C_STRETCH_EN defined:
- After the read ACK/NACK-phase scl_fall that precedes each RD byte, the slave drives scl_padoen_o=0 for STRETCH_CYC cycles, then releases SCL.
- SDA is set up during the stretch.
Without I2C_STRETCH_EN: scl_padoen_o is tied to 1.

Test Plan:
- Write: START, 0x20, 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; mem[3]=0xA5, mem[4]=0x5A; two wr_stb_o pulses with wr_adr_o 3 then 4; busy_o low after STOP.
- Address mismatch: START, 0x22, STOP -> SDA never driven (NACK seen); mem unchanged; busy_o stays 0.
- Combined read: START, 0x20, 0x03, repeated START, 0x21, master ACK, master NACK -> master reads 0xA5 then 0x5A; SDA released after NACK.
- Wrap: pointer 0x0F, write 0x11, 0x22 (MEM_AW=4) -> mem[15]=0x11, mem[0]=0x22.
- Abort: STOP after 4 data bits of a WR byte -> no write, state IDLE. Separately, arst_i=0 during RD -> sda_padoen_o=1 within reset; mem reads 0x00.
- Glitch: 2-cycle SCL low pulse with FILT_LEN=3 -> no bit clocked. With I2C_STRETCH_EN, a read byte shows SCL held low for 16 clocks.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C slave with an internal byte register file.
// SCL/SDA are oversampled on wb_clk_i, synchronised, glitch-filtered and
// decoded into START/STOP/edge events that drive a byte-level FSM.
// A pointer byte selects the register; writes and reads auto-increment
// with wrap. A side host port reads the register file combinationally.
// Optional build macro: I2C_STRETCH_EN holds SCL low for STRETCH_CYC
// cycles before each read byte; without it SCL is never driven.
`timescale 1ns/1ps
module i2c_slave_regs #(
  parameter logic [6:0] I2C_ADR     = 7'h10,
  parameter int         MEM_AW      = 4,
  parameter int         FILT_LEN    = 3,
  parameter int         STRETCH_CYC = 16
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              scl_pad_o,
  output logic              scl_padoen_o,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  input  logic [MEM_AW-1:0] hst_adr_i,
  output logic [7:0]        hst_dat_o,
  output logic              busy_o,
  output logic              wr_stb_o,
  output logic [MEM_AW-1:0] wr_adr_o
);

  localparam int         DEPTH    = 1 << MEM_AW;
  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADR_ACK, S_PTR, S_PTR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_e;

  // ---------------------------------------------------------------- input path
  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic       scl_prev_q, sda_prev_q;

  // Two-flop synchroniser shift plus per-line glitch filter.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_pad_i};
    sda_sync_d = {sda_sync_q[0], sda_pad_i};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    scl_cnt_d  = 4'd0;
    sda_cnt_d  = 4'd0;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == FILT_MAX) scl_f_d = scl_sync_q[1];
      else                       scl_cnt_d = scl_cnt_q + 4'd1;
    end
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == FILT_MAX) sda_f_d = sda_sync_q[1];
      else                       sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  // Input-path registers; idle bus level is high on both lines.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= 4'd0;
      sda_cnt_q  <= 4'd0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q &  scl_prev_q;
  assign start_det =  scl_f_q &  scl_prev_q &  sda_prev_q & ~sda_f_q;
  assign stop_det  =  scl_f_q &  scl_prev_q & ~sda_prev_q &  sda_f_q;

  // ---------------------------------------------------------------- byte FSM
  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              ack_on_q, ack_on_d;
  logic              rd_ok_q, rd_ok_d;
  logic              sda_oen_q, sda_oen_d;
  logic              busy_q, busy_d;
  logic              wr_stb_q, wr_stb_d;
  logic [MEM_AW-1:0] wr_adr_q, wr_adr_d;
  logic              mem_we;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        shift_in;
  logic [7:0]        rd_byte;

  assign shift_in = {sr_q[6:0], sda_f_q};
  assign rd_byte  = mem_q[ptr_q];

`ifdef I2C_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYC + 1);
  logic          stretch_go;
  logic [SW-1:0] stretch_q, stretch_d;
`else
  // The stretch length only matters when stretching is compiled in.
  logic unused_stretch;
  assign unused_stretch = (STRETCH_CYC != 0);
`endif

  // Next-state logic: START/STOP override everything, otherwise per-state work.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    ack_on_d  = ack_on_q;
    rd_ok_d   = rd_ok_q;
    sda_oen_d = sda_oen_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_adr_d  = wr_adr_q;
    mem_we    = 1'b0;
`ifdef I2C_STRETCH_EN
    stretch_go = 1'b0;
`endif
    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b1;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise) begin
            sr_d      = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_on_d  = 1'b0;
              if (state_q == S_ADDR) begin
                if (shift_in[7:1] == I2C_ADR) begin
                  state_d = S_ADR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = shift_in[MEM_AW-1:0];
                state_d = S_PTR_ACK;
              end else begin
                mem_we   = 1'b1;
                wr_stb_d = 1'b1;
                wr_adr_d = ptr_q;
                ptr_d    = ptr_q + MEM_AW'(1);
                state_d  = S_WR_ACK;
              end
            end
          end
        end
        S_ADR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oen_d = 1'b0;
              ack_on_d  = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              ack_on_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == S_ADR_ACK && sr_q[0]) begin
                state_d   = S_RD;
                sr_d      = rd_byte;
                sda_oen_d = rd_byte[7];
`ifdef I2C_STRETCH_EN
                stretch_go = 1'b1;
`endif
              end else if (state_q == S_ADR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WR;
              end
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oen_d = 1'b1;
              bit_cnt_d = 4'd0;
              rd_ok_d   = 1'b0;
              state_d   = S_RD_ACK;
            end else begin
              // Rotate so the next bit to send sits in bit 7.
              sr_d      = {sr_q[6:0], sr_q[7]};
              sda_oen_d = sr_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f_q) begin
              ptr_d   = ptr_q + MEM_AW'(1);
              rd_ok_d = 1'b1;
            end else begin
              state_d   = S_IDLE;
              sda_oen_d = 1'b1;
            end
          end else if (scl_fall && rd_ok_q) begin
            state_d   = S_RD;
            rd_ok_d   = 1'b0;
            sr_d      = rd_byte;
            sda_oen_d = rd_byte[7];
`ifdef I2C_STRETCH_EN
            stretch_go = 1'b1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM and protocol output registers.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      sr_q      <= 8'h00;
      ptr_q     <= '0;
      ack_on_q  <= 1'b0;
      rd_ok_q   <= 1'b0;
      sda_oen_q <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_adr_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      ptr_q     <= ptr_d;
      ack_on_q  <= ack_on_d;
      rd_ok_q   <= rd_ok_d;
      sda_oen_q <= sda_oen_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_adr_q  <= wr_adr_d;
    end
  end

  // Register file: written on the 8th data bit, read combinationally.
  // NOTE: the register file is flop-based and must come up as 0x00, so it is reset like any other state.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[ptr_q] <= shift_in;
    end
  end

`ifdef I2C_STRETCH_EN
  // Stretch counter: SCL is held low while it is non-zero.
  always_comb begin
    stretch_d = stretch_q;
    if (stretch_go)             stretch_d = SW'(STRETCH_CYC);
    else if (stretch_q != '0)   stretch_d = stretch_q - SW'(1);
  end

  // Stretch counter register.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) stretch_q <= '0;
    else         stretch_q <= stretch_d;
  end

  assign scl_padoen_o = (stretch_q == '0);
`else
  assign scl_padoen_o = 1'b1;
`endif

  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oen_q;
  assign hst_dat_o    = mem_q[hst_adr_i];
  assign busy_o       = busy_q;
  assign wr_stb_o     = wr_stb_q;
  assign wr_adr_o     = wr_adr_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master against i2c_slave_regs with a
// wired-AND bus, a register-file model and scoreboard queues for ACKs,
// read bytes and write strobes.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int MEM_AW = 4;
  localparam int Q      = 16;   // quarter SCL period in system clocks

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_scl, m_sda;
  logic              scl_bus, sda_bus;
  logic              scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [MEM_AW-1:0] hst_adr;
  logic [7:0]        hst_dat;
  logic              busy, wr_stb;
  logic [MEM_AW-1:0] wr_adr;

  always #5 clk = ~clk;

  assign scl_bus = m_scl & (scl_padoen_o | scl_pad_o);
  assign sda_bus = m_sda & (sda_padoen_o | sda_pad_o);

  i2c_slave_regs #(
    .I2C_ADR(7'h10), .MEM_AW(MEM_AW), .FILT_LEN(3), .STRETCH_CYC(16)
  ) dut (
    .wb_clk_i(clk), .arst_i(rst_n),
    .scl_pad_i(scl_bus), .sda_pad_i(sda_bus),
    .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .hst_adr_i(hst_adr), .hst_dat_o(hst_dat),
    .busy_o(busy), .wr_stb_o(wr_stb), .wr_adr_o(wr_adr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard queues and register-file model.
  logic              exp_ack_q[$];
  logic [7:0]        exp_rd_q[$];
  logic [MEM_AW-1:0] exp_wr_q[$];
  logic [7:0]        model_mem [16];
  logic [MEM_AW-1:0] m_ptr;

  // Bus monitors.
  logic sda_drv_seen = 1'b0;
  logic busy_seen    = 1'b0;
  int   stretch_run  = 0;
  int   stretch_last = 0;
  logic [MEM_AW-1:0] e_wr;

  always @(negedge clk) begin
    if (!sda_padoen_o) sda_drv_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!scl_padoen_o) stretch_run++;
    else if (stretch_run != 0) begin
      stretch_last = stretch_run;
      stretch_run  = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_stb === 1'b1) begin
      if (exp_wr_q.size() == 0) check("wr_stb_unexpected", 1, 0);
      else begin
        e_wr = exp_wr_q.pop_front();
        check("wr_adr", 32'(wr_adr), 32'(e_wr));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("scl_release_timeout", 0, 1);
  endtask

  task automatic bit_x(input logic b, input logic glitch, output logic s);
    m_sda = b;
    wait_cyc(Q);
    scl_high();
    wait_cyc(Q);
    if (glitch) begin
      m_scl = 1'b0;
      wait_cyc(2);
      m_scl = 1'b1;
      wait_cyc(Q);
    end
    s = sda_bus;
    wait_cyc(Q);
    m_scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1;
    wait_cyc(Q);
    scl_high();
    wait_cyc(Q);
    m_sda = 1'b0;
    wait_cyc(Q);
    m_scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    wait_cyc(Q);
    scl_high();
    wait_cyc(Q);
    m_sda = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input logic glitch);
    logic s;
    exp_ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) bit_x(b[i], glitch, s);
    bit_x(1'b1, 1'b0, s);
    check($sformatf("ack_%02h", b), 32'(!s), 32'(exp_ack_q.pop_front()));
  endtask

  task automatic wr_data(input logic [7:0] b, input logic glitch);
    exp_wr_q.push_back(m_ptr);
    model_mem[m_ptr] = b;
    m_ptr = m_ptr + 1'b1;
    wr_byte(b, 1'b1, glitch);
  endtask

  task automatic rd_byte(input logic master_ack);
    logic       s;
    logic [7:0] v = 8'h00;
    exp_rd_q.push_back(model_mem[m_ptr]);
    for (int i = 0; i < 8; i++) begin
      bit_x(1'b1, 1'b0, s);
      v = {v[6:0], s};
    end
    check("rd_byte", 32'(v), 32'(exp_rd_q.pop_front()));
    bit_x(!master_ack, 1'b0, s);
    if (master_ack) m_ptr = m_ptr + 1'b1;
  endtask

  task automatic host_chk(input logic [MEM_AW-1:0] a, input string tag);
    hst_adr = a;
    #1;
    check(tag, 32'(hst_dat), 32'(model_mem[a]));
  endtask

  task automatic set_ptr(input logic [7:0] p);
    start_c();
    wr_byte(8'h20, 1'b1, 1'b0);
    wr_byte(p, 1'b1, 1'b0);
    m_ptr = p[MEM_AW-1:0];
  endtask

  initial begin
    logic s;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    m_ptr   = '0;
    rst_n   = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    hst_adr = '0;
    wait_cyc(3);
    check("rst_scl_oen", 32'(scl_padoen_o), 1);
    check("rst_sda_oen", 32'(sda_padoen_o), 1);
    check("rst_busy",    32'(busy), 0);
    check("rst_wr_stb",  32'(wr_stb), 0);
    check("rst_wr_adr",  32'(wr_adr), 0);
    host_chk(4'd0, "rst_mem0");
    rst_n = 1'b1;
    wait_cyc(10);

    // Pointer write then two data bytes.
    set_ptr(8'h03);
    wr_data(8'hA5, 1'b0);
    wr_data(8'h5A, 1'b0);
    check("wr_busy_high", 32'(busy), 1);
    stop_c();
    wait_cyc(Q);
    check("wr_busy_low", 32'(busy), 0);
    check("wr_last_adr", 32'(wr_adr), 4);
    host_chk(4'd3, "wr_mem3");
    host_chk(4'd4, "wr_mem4");

    // Address mismatch: slave must stay silent.
    sda_drv_seen = 1'b0;
    busy_seen    = 1'b0;
    start_c();
    wr_byte(8'h22, 1'b0, 1'b0);
    stop_c();
    wait_cyc(Q);
    check("nack_sda_never", 32'(sda_drv_seen), 0);
    check("nack_busy_never", 32'(busy_seen), 0);
    host_chk(4'd3, "nack_mem3");

    // Combined read with repeated START.
    set_ptr(8'h03);
    start_c();
    wr_byte(8'h21, 1'b1, 1'b0);
    rd_byte(1'b1);
    rd_byte(1'b0);
    check("rd_nack_release", 32'(sda_padoen_o), 1);
    stop_c();
    wait_cyc(Q);

    // Pointer wrap on write.
    set_ptr(8'h0F);
    wr_data(8'h11, 1'b0);
    wr_data(8'h22, 1'b0);
    stop_c();
    wait_cyc(Q);
    host_chk(4'd15, "wrap_mem15");
    host_chk(4'd0,  "wrap_mem0");
    check("wrap_wr_adr", 32'(wr_adr), 0);

    // Abort after half a data byte.
    set_ptr(8'h05);
    for (int i = 0; i < 4; i++) bit_x(1'b1, 1'b0, s);
    stop_c();
    wait_cyc(Q);
    host_chk(4'd5, "abort_mem5");
    check("abort_busy", 32'(busy), 0);

    // Short SCL glitches inside each data bit must not clock extra bits.
    set_ptr(8'h07);
    wr_data(8'h3C, 1'b1);
    stop_c();
    wait_cyc(Q);
    host_chk(4'd7, "glitch_mem7");
    check("glitch_wr_adr", 32'(wr_adr), 7);

    // Read of a single byte to observe SCL behaviour.
    set_ptr(8'h00);
    start_c();
    wr_byte(8'h21, 1'b1, 1'b0);
    rd_byte(1'b0);
    stop_c();
    wait_cyc(Q);
`ifdef I2C_STRETCH_EN
    check("stretch_len", 32'(stretch_last), 16);
`else
    check("scl_never_held", 32'(stretch_last), 0);
`endif

    // Reset asserted while the slave drives a read bit.
    set_ptr(8'h00);
    start_c();
    wr_byte(8'h21, 1'b1, 1'b0);
    check("rd_bit7_driven", 32'(sda_padoen_o), 0);
    rst_n = 1'b0;
    #1;
    check("arst_sda_oen", 32'(sda_padoen_o), 1);
    check("arst_scl_oen", 32'(scl_padoen_o), 1);
    check("arst_busy",    32'(busy), 0);
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    host_chk(4'd0, "arst_mem0");
    host_chk(4'd3, "arst_mem3");
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(10);

    check("q_ack_empty", 32'(exp_ack_q.size()), 0);
    check("q_rd_empty",  32'(exp_rd_q.size()), 0);
    check("q_wr_empty",  32'(exp_wr_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
